// File: rtl/uint64_scan_pkg.sv
// Shared types and helpers for the 8x8 matrix scanner.
// Frame layout: row r occupies data[8r+7:8r].
package uint64_scan_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    PUBLISH
  } state_t;

  function automatic logic [ROWS-1:0] row_onehot(
    input logic [2:0] idx
  );
    logic [ROWS-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/uint64_scan_sync2.sv
// Two-flop synchroniser for the asynchronous column return lines.
// Both stages reset to zero.
module uint64_scan_sync2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [7:0] meta;

  // Two back-to-back capture stages
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uint64_scan.sv
// 8x8 matrix reader: one-hot row strobes, synchronised column sampling,
// 64-bit frame publish. Optional frame debounce: UINT64_SCAN_DEBOUNCE_EN.
module uint64_scan
  import uint64_scan_pkg::*;
#(
  parameter int SETTLE          = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  column,
  output logic [7:0]  row,
  output logic [63:0] data,
  output logic        valid,
  output logic        changed
);

  localparam int CW = $clog2(SETTLE + 1);

  state_t          state;
  state_t          state_nx;
  logic [2:0]      idx;
  logic [CW-1:0]   cnt;
  logic [63:0]     shadow;
  logic [63:0]     frame;
  logic [7:0]      col_s;
  logic            last;
  logic            pub_go;
  logic            publish;

  uint64_scan_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (column),
    .q     (col_s)
  );

  assign last   = (state == DRIVE) && (cnt == CW'(SETTLE - 1));
  assign pub_go = en && last && (idx == 3'd7);
  assign row    = (state == IDLE) ? '0 : row_onehot(idx);

  // Shadow with the row currently being sampled merged in
  always_comb begin
    frame = shadow;
    frame[{idx, 3'b000} +: 8] = col_s;
  end

  // Next-state logic; a low enable always wins
  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = DRIVE;
        DRIVE:   if (last && idx == 3'd7) state_nx = PUBLISH;
        PUBLISH: state_nx = DRIVE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Row index, settle counter and shadow frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      cnt    <= '0;
      shadow <= '0;
    end else if (!en || state == IDLE) begin
      idx <= '0;
      cnt <= '0;
    end else if (state == PUBLISH) begin
      // publish cycle already counts as row 0's first cycle
      cnt <= CW'(1);
    end else if (last) begin
      shadow <= frame;
      cnt    <= '0;
      idx    <= idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef UINT64_SCAN_DEBOUNCE_EN
  localparam int MW = $clog2(DEBOUNCE_FRAMES + 1);

  logic [MW-1:0] match;
  logic [MW-1:0] match_nx;
  logic [63:0]   prev;

  // Run length of identical completed frames, saturating
  always_comb begin
    match_nx = match;
    if (match == '0 || frame != prev)
      match_nx = MW'(1);
    else if (match != MW'(DEBOUNCE_FRAMES))
      match_nx = match + 1'b1;
  end

  assign publish = pub_go
                && match_nx == MW'(DEBOUNCE_FRAMES)
                && frame != data;

  // Previous completed frame and match count
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      match <= '0;
      prev  <= '0;
    end else if (!en) begin
      match <= '0;
    end else if (pub_go) begin
      match <= match_nx;
      prev  <= frame;
    end
  end
`else
  assign publish = pub_go;
`endif

  // Output frame register; valid/changed high only in the PUBLISH cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data    <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      valid   <= 1'b0;
      changed <= 1'b0;
      if (publish) begin
        data    <= frame;
        valid   <= 1'b1;
        changed <= (frame != data);
      end
    end
  end

endmodule

// File: tb/tb_uint64_scan.sv
// Directed + random bench for uint64_scan with a frame-level model.
// Column lines mirror a bench-held 64-bit pattern for the driven row.
module tb_uint64_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  column;
  logic [7:0]  row;
  logic [63:0] data;
  logic        valid;
  logic        changed;

  logic [63:0] pat;
  logic [63:0] mdata;
  logic [63:0] mprev;
  int          mcount;
  int          checks = 0;
  int          errors = 0;

  uint64_scan dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .column  (column),
    .row     (row),
    .data    (data),
    .valid   (valid),
    .changed (changed)
  );

  always #5 clock = ~clock;

  always_comb begin
    column = 8'h00;
    for (int r = 0; r < 8; r++)
      if (row == (8'd1 << r)) column = pat[8*r +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdata  = '0;
    mprev  = '0;
    mcount = 0;
  endtask

  task automatic model_abort();
    mcount = 0;
  endtask

  task automatic model_frame(input logic [63:0] f,
                             output logic ev, output logic ec);
`ifdef UINT64_SCAN_DEBOUNCE_EN
    if (mcount > 0 && f == mprev) mcount = (mcount >= 3) ? 3 : mcount + 1;
    else mcount = 1;
    mprev = f;
    ev = (mcount == 3) && (f != mdata);
    ec = ev;
    if (ev) mdata = f;
`else
    ev = 1'b1;
    ec = (f != mdata);
    mdata = f;
`endif
  endtask

  task automatic wait_row(input logic [7:0] r, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock);
      if (row === r) ok = 1'b1;
    end
  endtask

  // Enable from idle; returns on the first row-0 cycle
  task automatic start();
    en = 1'b1;
    @(negedge clock);
    chk("start_row", 64'(row), 64'h01);
  endtask

  // Called on a row-0 first cycle; returns on the next publish cycle
  task automatic run_frame(input logic [63:0] f);
    logic ev, ec;
    pat = f;
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      chk("quiet", 64'({valid, changed}), 64'h0);
    end
    @(negedge clock);
    model_frame(f, ev, ec);
    chk("valid", 64'(valid), 64'(ev));
    chk("changed", 64'(changed), 64'(ec));
    chk("data", data, mdata);
    chk("pub_row", 64'(row), 64'h01);
  endtask

  initial begin
    logic [63:0] f, q, g, r2;
    bit ok;
    reset = 1'b1;
    en    = 1'b0;
    pat   = '0;
    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_row", 64'(row), 64'h0);
    chk("rst_data", data, 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_changed", 64'(changed), 64'h0);

    // reset mid-scan
    pat = 64'hA7A6A5A4A3A2A1A0;
    en  = 1'b1;
    wait_row(8'h08, ok);
    chk("reach_row3", 64'(ok), 64'h1);
    reset = 1'b1;
    #1;
    chk("async_row", 64'(row), 64'h0);
    chk("async_data", data, 64'h0);
    chk("async_valid", 64'(valid), 64'h0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("settle_row0", 64'(row), 64'h01);
    end
    @(negedge clock);
    chk("next_row1", 64'(row), 64'h02);
    en = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_row", 64'(row), 64'h0);
    model_abort();

    // first frame, then a repeat of it
    start();
    run_frame(64'hA7A6A5A4A3A2A1A0);
    run_frame(64'hA7A6A5A4A3A2A1A0);

    repeat (3) run_frame({$urandom, $urandom});

    // enable dropped during row 3
    f = {$urandom, $urandom};
    pat = f;
    repeat (12) @(negedge clock);
    chk("row3", 64'(row), 64'h08);
    en = 1'b0;
    @(negedge clock);
    chk("drop_row", 64'(row), 64'h0);
    chk("drop_valid", 64'(valid), 64'h0);
    repeat (3) begin
      @(negedge clock);
      chk("idle_quiet", 64'({valid, changed}), 64'h0);
      chk("idle_data", data, mdata);
    end
    model_abort();
    start();
    run_frame({$urandom, $urandom});

    // enable dropped on row 7's final cycle
    f = {$urandom, $urandom};
    pat = f;
    repeat (31) @(negedge clock);
    chk("row7_last", 64'(row), 64'h80);
    en = 1'b0;
    @(negedge clock);
    chk("r7drop_valid", 64'(valid), 64'h0);
    chk("r7drop_row", 64'(row), 64'h0);
    chk("r7drop_data", data, mdata);
    model_abort();
    start();
    run_frame(f);

    // stable / glitch / stable sequences
    q  = {$urandom, $urandom};
    g  = q ^ 64'h0000_0100_0000_0000;
    r2 = ~q;
    repeat (4) run_frame(q);
    run_frame(g);
    repeat (3) run_frame(q);
    repeat (4) run_frame(r2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
